// File: rtl/psum_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_drain_pkg
// Purpose  : Shared accelerator constants and drain state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package psum_drain_pkg;

    localparam int PSUM_W     = 20;
    localparam int LANES      = 10;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psum_relu.sv
`default_nettype none
// ============================================================================
// Module   : psum_relu
// Purpose  : Optional ReLU clamp on a two's complement value, no width change.
// Revision : 1.0 - initial release
// ============================================================================
module psum_relu
    import psum_drain_pkg::*;
#(
    parameter int W = PSUM_W
) (
    input  logic [W-1:0] i_data,
    input  logic         i_en,
    output logic [W-1:0] o_data
);

    assign o_data = (i_en && i_data[W-1]) ? '0 : i_data;

endmodule
`default_nettype wire

// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
// Module   : psum_drain
// Purpose  : Captures a row of partial sums and streams one lane per beat.
// Revision : 1.0 - initial release
// ============================================================================
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int LANES  = psum_drain_pkg::LANES,
    parameter int W      = PSUM_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    output logic                load_ready,
    input  logic [LANES*W-1:0]  in_data,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                relu_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic                done
);

    localparam int                 c_IDX_W = $clog2(LANES);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(LANES - 1);

    state_t              r_state;
    logic [W-1:0]        r_lanes [LANES];
    logic [ADDR_W-1:0]   r_base;
    logic                r_relu;
    logic [c_IDX_W-1:0]  r_idx;

    logic [c_IDX_W-1:0]  w_nxt_idx;
    logic [W-1:0]        w_relu_din;
    logic                w_relu_en;
    logic [W-1:0]        w_relu_dout;

    // Outputs are pre-computed for the lane that will be presented next, so
    // the beat registers never depend combinationally on out_ready.
    assign w_nxt_idx  = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
    assign w_relu_din = (r_state == IDLE) ? in_data[W-1:0] : r_lanes[w_nxt_idx];
    assign w_relu_en  = (r_state == IDLE) ? relu_en : r_relu;

    psum_relu #(
        .W (W)
    ) u_relu (
        .i_data (w_relu_din),
        .i_en   (w_relu_en),
        .o_data (w_relu_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_relu     <= 1'b0;
            r_idx      <= '0;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_lanes[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_lanes[i] <= in_data[i*W +: W];
                        end
                        r_base     <= base_addr;
                        r_relu     <= relu_en;
                        r_idx      <= '0;
                        load_ready <= 1'b0;
                        out_valid  <= 1'b1;
                        out_data   <= w_relu_dout;
                        out_addr   <= base_addr;
                        out_last   <= (c_LAST == '0);
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_idx == c_LAST) begin
                            load_ready <= 1'b1;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            done       <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_idx    <= w_nxt_idx;
                            out_data <= w_relu_dout;
                            out_addr <= r_base + ADDR_W'(w_nxt_idx);
                            out_last <= (w_nxt_idx == c_LAST);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_drain
// Purpose  : Directed table-driven bench for psum_drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_drain;
    import psum_drain_pkg::*;

    localparam int W   = PSUM_W;
    localparam int AW  = DEF_ADDR_W;
    localparam int TMO = 200;

    logic                clk = 1'b0;
    logic                rst;
    logic                load;
    logic                load_ready;
    logic [LANES*W-1:0]  in_data;
    logic [AW-1:0]       base_addr;
    logic                relu_en;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [AW-1:0]       out_addr;
    logic                out_last;
    logic                done;

    always #5 clk = ~clk;

    psum_drain dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_ready (load_ready),
        .in_data    (in_data),
        .base_addr  (base_addr),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .done       (done)
    );

    typedef struct {
        logic [W-1:0]  lane [LANES];
        logic [AW-1:0] base;
        logic          relu;
        int            mode;
        logic [W-1:0]  exp_d3;
        logic [W-1:0]  exp_d4;
        logic [AW-1:0] exp_alast;
    } vec_t;

    vec_t          vecs [5];
    logic [W-1:0]  cur_lanes [LANES];
    logic [AW-1:0] cur_base;
    logic          cur_relu;
    logic [W-1:0]  cap_d3;
    logic [W-1:0]  cap_d4;
    logic [AW-1:0] cap_alast;
    logic [3:0]    ready_pat = 4'b1001;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] exp_data(input int k);
        return (cur_relu && cur_lanes[k][W-1]) ? '0 : cur_lanes[k];
    endfunction

    task automatic do_load();
        for (int i = 0; i < LANES; i++) in_data[i*W +: W] = cur_lanes[i];
        base_addr = cur_base;
        relu_en   = cur_relu;
        load      = 1'b1;
        chk("load_ready_before_load", load_ready, 1);
        @(negedge clk);
        load    = 1'b0;
        in_data = '0;
    endtask

    // Entered on the first SEND cycle; leaves on the cycle after the last transfer.
    task automatic drain(input int mode, input bit spam);
        int            k = 0;
        int            cyc = 0;
        bit            stalled = 0;
        logic [W-1:0]  sd;
        logic [AW-1:0] sa;
        logic          sl;
        logic [AW-1:0] ea;
        while (k < LANES && cyc < TMO) begin
            out_ready = (mode == 0) ? 1'b1 : ready_pat[cyc % 4];
            if (spam) begin
                load      = 1'b1;
                relu_en   = ~cur_relu;
                base_addr = AW'(12'hABC + cyc);
                for (int i = 0; i < LANES; i++) in_data[i*W +: W] = W'(20'hDEAD0 + cyc + i);
            end
            chk("beat_valid", out_valid, 1);
            if (stalled) begin
                chk("stall_hold_data", out_data, sd);
                chk("stall_hold_addr", out_addr, sa);
                chk("stall_hold_last", out_last, sl);
            end
            ea = cur_base + AW'(k);
            chk("beat_data", out_data, exp_data(k));
            chk("beat_addr", out_addr, ea);
            chk("beat_last", out_last, (k == LANES - 1));
            if (out_ready && out_valid === 1'b1) begin
                if (k == 3) cap_d3 = out_data;
                if (k == 4) cap_d4 = out_data;
                if (k == LANES - 1) cap_alast = out_addr;
                k++;
                stalled = 0;
            end else begin
                stalled = 1;
                sd = out_data;
                sa = out_addr;
                sl = out_last;
            end
            cyc++;
            @(negedge clk);
        end
        if (k < LANES) chk("drain_timeout_beats", k, LANES);
        if (mode == 0) chk("drain_cycle_count", cyc, LANES);
    endtask

    task automatic check_done();
        chk("done_pulse", done, 1);
        chk("done_load_ready", load_ready, 1);
        chk("done_valid_low", out_valid, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; out_ready = 1'b0;
        in_data = '0; base_addr = '0; relu_en = 1'b0;

        for (int k = 0; k < LANES; k++) begin
            vecs[0].lane[k] = W'(k + 1);
            vecs[1].lane[k] = W'((k + 1) * 20'h01111);
            vecs[2].lane[k] = W'(20'h00100 + k);
            vecs[4].lane[k] = W'(20'h000A0 + k);
        end
        vecs[2].lane[3] = 20'hFFFFF;
        vecs[2].lane[4] = 20'h7FFFF;
        vecs[2].lane[7] = 20'h80000;
        vecs[3].lane    = vecs[2].lane;
        vecs[0].base = 12'h100; vecs[0].relu = 0; vecs[0].mode = 0;
        vecs[0].exp_d3 = 20'h4; vecs[0].exp_d4 = 20'h5; vecs[0].exp_alast = 12'h109;
        vecs[1].base = 12'h200; vecs[1].relu = 0; vecs[1].mode = 1;
        vecs[1].exp_d3 = 20'h04444; vecs[1].exp_d4 = 20'h05555; vecs[1].exp_alast = 12'h209;
        vecs[2].base = 12'h000; vecs[2].relu = 1; vecs[2].mode = 0;
        vecs[2].exp_d3 = 20'h00000; vecs[2].exp_d4 = 20'h7FFFF; vecs[2].exp_alast = 12'h009;
        vecs[3].base = 12'h3F0; vecs[3].relu = 0; vecs[3].mode = 1;
        vecs[3].exp_d3 = 20'hFFFFF; vecs[3].exp_d4 = 20'h7FFFF; vecs[3].exp_alast = 12'h3F9;
        vecs[4].base = 12'hFFC; vecs[4].relu = 1; vecs[4].mode = 0;
        vecs[4].exp_d3 = 20'h000A3; vecs[4].exp_d4 = 20'h000A4; vecs[4].exp_alast = 12'h005;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            cur_lanes = vecs[v].lane;
            cur_base  = vecs[v].base;
            cur_relu  = vecs[v].relu;
            do_load();
            drain(vecs[v].mode, 0);
            chk("vec_lane3_data", cap_d3, vecs[v].exp_d3);
            chk("vec_lane4_data", cap_d4, vecs[v].exp_d4);
            chk("vec_last_addr", cap_alast, vecs[v].exp_alast);
            check_done();
        end

        // Back-to-back with load held high throughout the first batch
        for (int k = 0; k < LANES; k++) cur_lanes[k] = W'(20'h00300 + k);
        cur_base = 12'h040; cur_relu = 1'b0;
        do_load();
        drain(0, 1);
        chk("b2b_done", done, 1);
        chk("b2b_load_ready", load_ready, 1);
        for (int k = 0; k < LANES; k++) cur_lanes[k] = W'(20'h00500 + k);
        cur_base = 12'h080;
        for (int i = 0; i < LANES; i++) in_data[i*W +: W] = cur_lanes[i];
        base_addr = cur_base; relu_en = cur_relu; load = 1'b1;
        @(negedge clk);
        load = 1'b0; in_data = '0;
        chk("b2b_done_cleared", done, 0);
        chk("b2b_batch2_valid", out_valid, 1);
        chk("b2b_batch2_lane0", out_data, 20'h00500);
        drain(0, 0);
        check_done();

        // Reset after lane 4 has transferred
        for (int k = 0; k < LANES; k++) cur_lanes[k] = W'(20'h00600 + k);
        cur_base = 12'h010; cur_relu = 1'b0;
        do_load();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("rsm_beat_data", out_data, W'(20'h00600 + k));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsm_valid_low", out_valid, 0);
        chk("rsm_load_ready", load_ready, 1);
        chk("rsm_no_done", done, 0);
        chk("rsm_last_low", out_last, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rsm_no_done_later", done, 0);
        end
        for (int k = 0; k < LANES; k++) cur_lanes[k] = W'(20'h00700 + k);
        cur_base = 12'h020;
        do_load();
        drain(0, 0);
        check_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_drain.md
# psum_drain

Parallel-to-serial reader for the per-row partial-sum temporary register bank of the CNN accelerator. On a load strobe it captures all lanes of 20-bit partial sums in one cycle, then streams them out one lane per beat over a valid/ready handshake toward the output SRAM write port. Each beat carries a generated address and an optional ReLU. This frees the temp bank to accept the next row while the previous row drains.

## Interface
- LANES, 10, number of partial-sum lanes captured per load
- W, 20, partial-sum width (two's complement)
- ADDR_W, 12, output SRAM address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- load  in  1  capture strobe, honoured only when load_ready=1
- load_ready  out  1  block can accept a load this cycle
- in_data  in  LANES*W  flat lanes, lane i = in_data[i*W +: W]
- base_addr  in  ADDR_W  address of lane 0, sampled with load
- relu_en  in  1  clamp negatives to zero, sampled with load
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_data  out  W  current lane value (post-ReLU)
- out_addr  out  ADDR_W  base_addr + lane index, modulo 2^ADDR_W
- out_last  out  1  current beat is lane LANES-1
- done  out  1  one-cycle pulse after the final beat transfers

## Operation
- States: IDLE, SEND.
- IDLE:
  - load_ready=1, out_valid=0.
  - load=1 captures in_data, base_addr and relu_en into internal registers, clears the lane index to 0, and moves to SEND.
- SEND:
  - load_ready=0; load is ignored and does not disturb the captured data.
  - out_valid=1; out_data is lane[idx], out_addr is base+idx, out_last=(idx==LANES-1).
  - A transfer (out_valid & out_ready) advances idx by 1.
  - A transfer with out_last=1 returns the block to IDLE.
  - With out_ready=0, all outputs hold stable and idx does not change.
- done:
  - Registered; high for exactly the one cycle following the final transfer.
  - That is the first IDLE cycle, so a load in the same cycle is accepted.
- ReLU: when the captured relu_en=1 and lane MSB=1, out_data=0. Otherwise the lane passes through unchanged. There is no width change.
- Address arithmetic: ADDR_W-bit add that wraps silently (base 0xFFF, idx 1 gives 0x000).
- Reset mid-stream: return to IDLE next edge, abandon remaining lanes, no done pulse.
- Reset values:
  - load_ready=1, out_valid=0, out_last=0, done=0.
  - out_data=0, out_addr=0, captured lanes=0, idx=0.

## Timing
- Load accepted at edge t; first beat (lane 0) is valid from cycle t+1.
- With out_ready held at 1, lanes 0..LANES-1 occupy cycles t+1..t+LANES. done is high at t+LANES+1, and load_ready is high the same cycle.
- Minimum batch period is LANES+1 cycles.
- out_* are driven from registers, with no combinational path from out_ready to out_valid or out_data. The only combinational use of out_ready is advancing the state.
- load and in_data are not required to be stable after the capture edge.

## Structure
- The shared accelerator package holds:
  - PSUM_W=20, LANES=10
  - state enum {IDLE, SEND}
  - ADDR_W default
- idx width is $clog2(LANES).
- One natural sub-module: psum_relu (combinational, W-bit, enable). It is reusable by other output paths.
- Everything else is one module: capture registers, index counter, FSM.

## Test plan
- Basic drain:
  - Stimulus: lanes = 1..10, base 0x100, relu_en=0, out_ready=1.
  - Response: ten beats with data 1..10 and addr 0x100..0x109, out_last only on the tenth beat, done one cycle later.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... with lane values distinct.
  - Response: data, addr and last stay stable while stalled; no lane is skipped or duplicated; total transfers = 10.
- ReLU:
  - Stimulus: lane 3 = 20'hFFFFF (−1), lane 4 = 20'h7FFFF, relu_en=1.
  - Response: beat 3 data=0, beat 4 data=20'h7FFFF. Rerunning with relu_en=0 gives beat 3 = 20'hFFFFF.
- Back-to-back and ignored load:
  - Stimulus: assert load every cycle with changing in_data.
  - Response: only the loads accepted when load_ready=1 take effect. Batch 2 begins the cycle after done, and batch 1 data is uncorrupted by loads issued during SEND.
- Address wrap:
  - Stimulus: base 0xFFC.
  - Response: addresses 0xFFC, 0xFFD, 0xFFE, 0xFFF, 0x000 … 0x005.
- Reset mid-stream:
  - Stimulus: rst=1 after lane 4 transfers.
  - Response: next cycle out_valid=0, load_ready=1, done never pulses. A new load then restarts from lane 0.
